ks_sub_pipe: RTL and testbench
==============================

Name: ks_sub_pipe

Overview:
- Pipelined 32-bit Kogge-Stone subtractor computing a − b as a + ~b + 1.
- Inverse-direction companion to the existing combinational prefix adder: it reuses the same black/grey prefix cells, with pipeline registers and a valid/ready stream interface.
- Sits between an operand producer (ALU issue) and a result consumer (writeback/compare logic).
- Carries a sideband tag so out-of-band context travels with each result.

Parameters:
- WIDTH, 32, operand width; fixed at 32 in this release (5 prefix levels).
- TAG_W, 4, width of sideband tag carried with each operation.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous active-high reset
- in_valid  in  1  operand pair present
- in_ready  out  1  block can accept operands this cycle
- in_a  in  WIDTH  minuend
- in_b  in  WIDTH  subtrahend
- in_tag  in  TAG_W  sideband, returned unchanged with the result
- out_valid  out  1  result present
- out_ready  in  1  consumer accepts result this cycle
- out_diff  out  WIDTH  a − b mod 2^WIDTH
- out_cout  out  1  carry out of a + ~b + 1 (1 = no borrow, i.e. a ≥ b unsigned)
- out_tag  out  TAG_W  tag of this result
- out_zero  out  1  diff == 0 (see Optional Feature)
- out_ovf  out  1  signed overflow (see Optional Feature)

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high (rst).
- Transfer rules:
  - Input transfer when in_valid && in_ready.
  - Output transfer when out_valid && out_ready.
- Pipeline: three register stages S1, S2, S3. Each stage has its own valid bit.
  - S1: p[i] = a[i] ^ ~b[i], g[i] = a[i] & ~b[i]. The injected carry-in of 1 folds into bit 0 as g00 = g[0] | p[0]. Also holds the raw p vector for the sum XOR, plus tag.
  - S2: prefix levels 1–3 (distances 1, 2, 4). Grey cells where the span reaches bit 0, black cells elsewhere, buffers for positions below the distance.
  - S3: levels 4–5 (distances 8, 16), then sum[i] = p[i] ^ G[i−1], with G[−1] = 1. cout = G[31].
- S3 drives the outputs directly: out_valid = S3.valid; data outputs come from S3 registers.
- Latency: 3 cycles from input transfer to out_valid with no stall. Throughput is 1 result per cycle.
- Stall/advance:
  - adv3 = !S3.valid || out_ready
  - adv2 = !S2.valid || adv3
  - adv1 = !S1.valid || adv2
  - in_ready = adv1, driven combinationally from out_ready and the valid bits.
  - Bubbles collapse: an empty stage accepts from upstream even when downstream is stalled.
- A stage that does not advance holds its data and valid bit unchanged.
- Data registers load only when the stage advances; valid bits load the upstream valid on advance.
- Reset:
  - All valid bits clear to 0, so in_ready = 1 the cycle after reset.
  - out_diff, out_cout, out_tag, out_zero and out_ovf all reset to 0.
  - Reset mid-operation discards all in-flight results; no output transfer occurs in the reset cycle.
- Simultaneous accept and emit with a full pipeline and out_ready = 1: all stages shift; no loss, no duplication.
- Output stability: while out_valid && !out_ready, all out_* signals stay stable. in_valid may be deasserted by the producer at any time; in_a, in_b and in_tag are sampled only on transfer.
- Wrap-around: results are modulo 2^32; no saturation.

Optional Feature:
- Macro KS_SUB_FLAGS_EN.
- When defined:
  - out_zero = (diff == 0), registered in S3.
  - out_ovf = (a[31] != b[31]) && (diff[31] != a[31]). The operand sign bits are carried through S1/S2 to compute this.
- When undefined: out_zero and out_ovf are tied to 0, and the sign-bit pipeline registers are not built.

Decomposition:
- Package ks_pkg:
  - KS_WIDTH = 32, KS_LEVELS = 5.
  - typedef pg_t (packed struct: p, g vectors of KS_WIDTH).
  - Function ks_dist(level) = 1 << (level−1).
- One sub-module, ks_prefix_level: combinational, parameter DIST.
  - Produces buffer, grey and black cells for one prefix level from p/g in to p/g out.
  - Instantiated 5 times across S2/S3.

Test Plan:
- Reset, then a = 0x0000_000A, b = 0x0000_0003, tag = 5, out_ready = 1 → out_valid exactly 3 cycles after accept; diff = 0x0000_0007, cout = 1, tag = 5.
- a = 0x0000_0000, b = 0x0000_0001 → diff = 0xFFFF_FFFF, cout = 0; with KS_SUB_FLAGS_EN: zero = 0, ovf = 0.
- a = 0x8000_0000, b = 0x0000_0001 → diff = 0x7FFF_FFFF, cout = 1; ovf = 1 when flags are enabled. Also a = b = 0x1234_5678 → diff = 0, zero = 1.
- Back-to-back stream of 4 ops, out_ready held 0 for 5 cycles:
  - in_ready drops after 3 accepts.
  - Outputs stay stable during the stall.
  - On release, results emerge in order with correct tags and no drop/duplication.
- Bubble collapse: one op stalled in S3 while S1/S2 are empty → in_ready stays 1, and two further ops are accepted into S2/S1.
- Assert rst with 3 ops in flight → next cycle out_valid = 0, in_ready = 1, all outputs 0; a new op then completes normally with 3-cycle latency.

Source files
------------

// File: rtl/ks_pkg.sv
// ks_pkg
//   Shared definitions for the Kogge-Stone prefix datapath: operand width,
//   number of prefix levels, the propagate/generate vector pair and the
//   per-level span helper.
package ks_pkg;

  localparam int KS_WIDTH     = 32;
  localparam int KS_LEVELS    = 5;
  // Prefix levels evaluated in S2; the remaining ones are evaluated in S3.
  localparam int KS_S2_LEVELS = 3;

  typedef struct packed {
    logic [KS_WIDTH-1:0] p;
    logic [KS_WIDTH-1:0] g;
  } pg_t;

  // Distance spanned by one prefix level (level counts from 1).
  function automatic int ks_dist(input int level);
    return 1 << (level - 1);
  endfunction

endpackage

// File: rtl/ks_prefix_level.sv
// ks_prefix_level
//   One combinational Kogge-Stone prefix level.
//   Bit positions below DIST are buffered. Positions whose combined span
//   reaches bit 0 use a grey cell (only G is meaningful from then on). All
//   other positions use a black cell (G and P both combined).
// Ports:
//   pg_in   propagate/generate vectors entering the level
//   pg_out  propagate/generate vectors leaving the level
module ks_prefix_level
  import ks_pkg::*;
#(
  parameter int DIST = 1
) (
  input  pg_t pg_in,
  output pg_t pg_out
);

  genvar gi;
  for (gi = 0; gi < KS_WIDTH; gi++) begin : g_bit
    if (gi < DIST) begin : g_buf
      assign pg_out.p[gi] = pg_in.p[gi];
      assign pg_out.g[gi] = pg_in.g[gi];
    end else if (gi < 2 * DIST) begin : g_grey
      // Span now covers bit 0, so this G is final. P is passed through only
      // to keep the vector complete; no later cell consumes it.
      assign pg_out.g[gi] = pg_in.g[gi] | (pg_in.p[gi] & pg_in.g[gi-DIST]);
      assign pg_out.p[gi] = pg_in.p[gi];
    end else begin : g_black
      assign pg_out.g[gi] = pg_in.g[gi] | (pg_in.p[gi] & pg_in.g[gi-DIST]);
      assign pg_out.p[gi] = pg_in.p[gi] & pg_in.p[gi-DIST];
    end
  end

endmodule

// File: rtl/ks_sub_pipe.sv
// ks_sub_pipe
//   Three-stage pipelined 32-bit Kogge-Stone subtractor: diff = a + ~b + 1.
//   S1 forms p/g (carry-in folded into bit 0), S2 runs prefix levels 1-3,
//   S3 runs levels 4-5 and forms the sum. S3 registers drive the outputs.
//   Valid/ready on both sides; an empty stage always accepts from upstream.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   in_valid/in_ready         operand handshake
//   in_a, in_b, in_tag        minuend, subtrahend, sideband tag
//   out_valid/out_ready       result handshake
//   out_diff, out_cout        a - b mod 2^WIDTH, carry out (1 = a >= b)
//   out_tag                   tag of the result
//   out_zero, out_ovf         diff == 0, signed overflow
// Configuration:
//   KS_SUB_FLAGS_EN  builds the zero/overflow flags and the sign-bit
//                    registers; otherwise out_zero/out_ovf are tied to 0.
module ks_sub_pipe
  import ks_pkg::*;
#(
  parameter int WIDTH = 32,   // fixed at 32 (five prefix levels)
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_diff,
  output logic             out_cout,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_zero,
  output logic             out_ovf
);

  localparam int S3_LEVELS = KS_LEVELS - KS_S2_LEVELS;

  logic adv1, adv2, adv3;
  logic s1_valid_reg, s2_valid_reg, s3_valid_reg;

  pg_t                 s1_pg_next;
  pg_t                 s1_pg_reg;
  logic [TAG_W-1:0]    s1_tag_reg;
  pg_t                 s2_pg_reg;
  logic [KS_WIDTH-1:0] s2_p_reg;
  logic [TAG_W-1:0]    s2_tag_reg;
  logic [KS_WIDTH-1:0] s3_diff_reg;
  logic                s3_cout_reg;
  logic [TAG_W-1:0]    s3_tag_reg;

  logic [KS_WIDTH-1:0] b_inv;
  logic [KS_WIDTH-1:0] carry_g;
  logic [KS_WIDTH-1:0] diff_next;
  logic                unused_final_p;

  pg_t s2_chain [KS_S2_LEVELS+1];
  pg_t s3_chain [S3_LEVELS+1];

  // Stall chain: a stage moves if it is empty or its successor moves.
  assign adv3     = !s3_valid_reg || out_ready;
  assign adv2     = !s2_valid_reg || adv3;
  assign adv1     = !s1_valid_reg || adv2;
  assign in_ready = adv1;

  // S1 inputs: p/g of a + ~b, with the +1 carry-in absorbed into g[0].
  assign b_inv         = ~in_b;
  assign s1_pg_next.p  = in_a ^ b_inv;
  assign s1_pg_next.g  = {in_a[KS_WIDTH-1:1] & b_inv[KS_WIDTH-1:1],
                          (in_a[0] & b_inv[0]) | (in_a[0] ^ b_inv[0])};

  // S2 combinational prefix levels 1..3.
  assign s2_chain[0] = s1_pg_reg;
  genvar gi;
  for (gi = 0; gi < KS_S2_LEVELS; gi++) begin : g_s2_level
    ks_prefix_level #(.DIST(ks_dist(gi + 1))) u_level (
      .pg_in  (s2_chain[gi]),
      .pg_out (s2_chain[gi+1])
    );
  end

  // S3 combinational prefix levels 4..5.
  assign s3_chain[0] = s2_pg_reg;
  for (gi = 0; gi < S3_LEVELS; gi++) begin : g_s3_level
    ks_prefix_level #(.DIST(ks_dist(KS_S2_LEVELS + gi + 1))) u_level (
      .pg_in  (s3_chain[gi]),
      .pg_out (s3_chain[gi+1])
    );
  end

  // G[i] is the carry out of bit i; the carry into bit 0 is the injected 1.
  assign carry_g        = s3_chain[S3_LEVELS].g;
  assign diff_next      = s2_p_reg ^ {carry_g[KS_WIDTH-2:0], 1'b1};
  // Group propagates of the last level have no consumer.
  assign unused_final_p = &{1'b0, s3_chain[S3_LEVELS].p};

  // Valid bits and the output-facing S3 registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_reg <= 1'b0;
      s2_valid_reg <= 1'b0;
      s3_valid_reg <= 1'b0;
      s3_diff_reg  <= '0;
      s3_cout_reg  <= 1'b0;
      s3_tag_reg   <= '0;
    end else begin
      if (adv1) s1_valid_reg <= in_valid;
      if (adv2) s2_valid_reg <= s1_valid_reg;
      if (adv3) begin
        s3_valid_reg <= s2_valid_reg;
        if (s2_valid_reg) begin
          s3_diff_reg <= diff_next;
          s3_cout_reg <= carry_g[KS_WIDTH-1];
          s3_tag_reg  <= s2_tag_reg;
        end
      end
    end
  end

  // S1/S2 datapath registers need no reset: they are qualified by valid.
  always_ff @(posedge clk) begin
    if (adv1 && in_valid) begin
      s1_pg_reg  <= s1_pg_next;
      s1_tag_reg <= in_tag;
    end
    if (adv2 && s1_valid_reg) begin
      s2_pg_reg  <= s2_chain[KS_S2_LEVELS];
      s2_p_reg   <= s1_pg_reg.p;
      s2_tag_reg <= s1_tag_reg;
    end
  end

`ifdef KS_SUB_FLAGS_EN
  logic s1_sa_reg, s1_sb_reg, s2_sa_reg, s2_sb_reg;
  logic s3_zero_reg, s3_ovf_reg;

  always_ff @(posedge clk) begin
    if (adv1 && in_valid) begin
      s1_sa_reg <= in_a[WIDTH-1];
      s1_sb_reg <= in_b[WIDTH-1];
    end
    if (adv2 && s1_valid_reg) begin
      s2_sa_reg <= s1_sa_reg;
      s2_sb_reg <= s1_sb_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s3_zero_reg <= 1'b0;
      s3_ovf_reg  <= 1'b0;
    end else if (adv3 && s2_valid_reg) begin
      s3_zero_reg <= (diff_next == '0);
      // Overflow only when operand signs differ and the result sign
      // disagrees with the minuend.
      s3_ovf_reg  <= (s2_sa_reg != s2_sb_reg) &&
                     (diff_next[KS_WIDTH-1] != s2_sa_reg);
    end
  end

  assign out_zero = s3_zero_reg;
  assign out_ovf  = s3_ovf_reg;
`else
  assign out_zero = 1'b0;
  assign out_ovf  = 1'b0;
`endif

  assign out_valid = s3_valid_reg;
  assign out_diff  = s3_diff_reg;
  assign out_cout  = s3_cout_reg;
  assign out_tag   = s3_tag_reg;

endmodule

// File: tb/tb_ks_sub_pipe.sv
// tb_ks_sub_pipe
//   Directed and randomized checks of ks_sub_pipe against an arithmetic
//   reference model held in a queue of expected results.
module tb_ks_sub_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [3:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_diff;
  logic        out_cout;
  logic [3:0]  out_tag;
  logic        out_zero;
  logic        out_ovf;

  always #5 clk = ~clk;

  ks_sub_pipe #(.WIDTH(32), .TAG_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_diff  (out_diff),
    .out_cout  (out_cout),
    .out_tag   (out_tag),
    .out_zero  (out_zero),
    .out_ovf   (out_ovf)
  );

  typedef struct packed {
    logic [31:0] diff;
    logic        cout;
    logic [3:0]  tag;
    logic        zero;
    logic        ovf;
  } exp_t;

  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_out    = 0;
  exp_t q[$];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
  endtask

  // Reference: plain integer arithmetic on the operands.
  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b, input logic [3:0] t);
    exp_t e;
    e.diff = a - b;
    e.cout = (a >= b);
    e.tag  = t;
`ifdef KS_SUB_FLAGS_EN
    begin
      longint sd;
      sd     = longint'($signed(a)) - longint'($signed(b));
      e.zero = (a == b);
      e.ovf  = (sd > 64'sd2147483647) || (sd < -64'sd2147483648);
    end
`else
    e.zero = 1'b0;
    e.ovf  = 1'b0;
`endif
    return e;
  endfunction

  // Scoreboard monitor, sampling on the falling edge.
  exp_t mon_e;
  exp_t prev_out;
  logic prev_stall = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      prev_stall = 1'b0;
    end else begin
      if (prev_stall)
        check("stable", 64'({out_valid, out_diff, out_cout, out_tag, out_zero, out_ovf}),
              64'({1'b1, prev_out}));
      if (out_valid) begin
        if (q.size() == 0) begin
          check("spurious_out", 64'd1, 64'd0);
        end else begin
          mon_e = q[0];
          check("diff", 64'(out_diff), 64'(mon_e.diff));
          check("cout", 64'(out_cout), 64'(mon_e.cout));
          check("tag",  64'(out_tag),  64'(mon_e.tag));
          check("zero", 64'(out_zero), 64'(mon_e.zero));
          check("ovf",  64'(out_ovf),  64'(mon_e.ovf));
          if (out_ready) begin
            $display("out %0d: diff=%08h cout=%0b tag=%0h zero=%0b ovf=%0b",
                     n_out, out_diff, out_cout, out_tag, out_zero, out_ovf);
            void'(q.pop_front());
            n_out++;
          end
        end
      end
      prev_stall = out_valid && !out_ready;
      prev_out   = {out_diff, out_cout, out_tag, out_zero, out_ovf};
      if (in_valid && in_ready) q.push_back(model(in_a, in_b, in_tag));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic [3:0] t);
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_tag   = t;
  endtask

  task automatic drain(input string nm);
    int cyc;
    cyc = 0;
    step();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while ((q.size() != 0 || out_valid) && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    check({nm, "_drained"}, 64'(q.size()), 64'd0);
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [3:0] t,
                        input logic [31:0] ed, input logic ec, input logic ez, input logic eo,
                        input string nm);
    int lat;
    bit got;
    step();
    out_ready = 1'b1;
    drive(a, b, t);
    @(negedge clk);
    check({nm, "_in_ready"}, 64'(in_ready), 64'd1);
    step();
    in_valid = 1'b0;
    lat = 0;
    got = 1'b0;
    while (!got && lat < 20) begin
      @(negedge clk);
      lat++;
      got = out_valid;
    end
    check({nm, "_latency"}, 64'(lat), 64'd3);
    check({nm, "_diff"}, 64'(out_diff), 64'(ed));
    check({nm, "_cout"}, 64'(out_cout), 64'(ec));
    check({nm, "_tag"},  64'(out_tag),  64'(t));
`ifdef KS_SUB_FLAGS_EN
    check({nm, "_zero"}, 64'(out_zero), 64'(ez));
    check({nm, "_ovf"},  64'(out_ovf),  64'(eo));
`else
    check({nm, "_zero"}, 64'(out_zero), 64'(ez & 1'b0));
    check({nm, "_ovf"},  64'(out_ovf),  64'(eo & 1'b0));
`endif
  endtask

  task automatic stall_test();
    logic [31:0] oa [4];
    logic [31:0] ob [4];
    int idx, cyc, base;
    for (int k = 0; k < 4; k++) begin
      oa[k] = $urandom;
      ob[k] = $urandom;
    end
    idx  = 0;
    base = n_out;
    for (int c = 0; c < 8; c++) begin
      step();
      out_ready = 1'b0;
      if (idx < 4) drive(oa[idx], ob[idx], 4'(8 + idx));
      else in_valid = 1'b0;
      @(negedge clk);
      if (in_valid && in_ready) idx++;
    end
    check("stall_accepts",   64'(idx), 64'd3);
    check("stall_in_ready",  64'(in_ready), 64'd0);
    check("stall_out_valid", 64'(out_valid), 64'd1);
    cyc = 0;
    while (idx < 4 && cyc < 20) begin
      step();
      out_ready = 1'b1;
      drive(oa[idx], ob[idx], 4'(8 + idx));
      @(negedge clk);
      if (in_ready) idx++;
      cyc++;
    end
    step();
    in_valid = 1'b0;
    cyc = 0;
    while (n_out < base + 4 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    @(negedge clk);
    check("stall_emitted", 64'(n_out - base), 64'd4);
  endtask

  task automatic bubble_test();
    int cyc;
    step();
    out_ready = 1'b0;
    drive($urandom, $urandom, 4'h1);
    @(negedge clk);
    check("bub_first_acc", 64'(in_ready), 64'd1);
    step();
    in_valid = 1'b0;
    cyc = 0;
    @(negedge clk);
    while (!out_valid && cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    check("bub_s3_valid", 64'(out_valid), 64'd1);
    check("bub_in_ready", 64'(in_ready), 64'd1);
    for (int k = 0; k < 2; k++) begin
      step();
      drive($urandom, $urandom, 4'(2 + k));
      @(negedge clk);
      check("bub_accept", 64'(in_ready), 64'd1);
    end
    step();
    in_valid = 1'b0;
    @(negedge clk);
    check("bub_full", 64'(in_ready), 64'd0);
    drain("bubble");
  endtask

  task automatic reset_test();
    for (int k = 0; k < 3; k++) begin
      step();
      out_ready = 1'b1;
      drive($urandom | 32'h1000_0000, $urandom & 32'h0FFF_FFFF, 4'(13 + k));
      @(negedge clk);
      check("rst_accept", 64'(in_ready), 64'd1);
    end
    step();
    in_valid = 1'b0;
    rst      = 1'b1;
    @(negedge clk);
    step();
    rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready",  64'(in_ready),  64'd1);
    check("rst_diff",      64'(out_diff),  64'd0);
    check("rst_cout",      64'(out_cout),  64'd0);
    check("rst_tag",       64'(out_tag),   64'd0);
    check("rst_zero",      64'(out_zero),  64'd0);
    check("rst_ovf",       64'(out_ovf),   64'd0);
    run_op(32'd100, 32'd58, 4'h6, 32'd42, 1'b1, 1'b0, 1'b0, "post_rst");
  endtask

  task automatic pick_operands(output logic [31:0] a, output logic [31:0] b);
    logic [31:0] edges [4];
    edges[0] = 32'h0000_0000;
    edges[1] = 32'hFFFF_FFFF;
    edges[2] = 32'h8000_0000;
    edges[3] = 32'h7FFF_FFFF;
    case ($urandom_range(5))
      0: begin a = $urandom; b = a; end
      1: begin a = {1'b1, 31'($urandom)}; b = {1'b0, 31'($urandom)}; end
      2: begin a = {1'b0, 31'($urandom)}; b = {1'b1, 31'($urandom)}; end
      3: begin a = edges[$urandom_range(3)]; b = edges[$urandom_range(3)]; end
      default: begin a = $urandom; b = $urandom; end
    endcase
  endtask

  task automatic random_test();
    logic [31:0] a, b;
    for (int c = 0; c < 400; c++) begin
      step();
      out_ready = ($urandom_range(9) < 6);
      if ($urandom_range(9) < 7) begin
        pick_operands(a, b);
        drive(a, b, 4'($urandom));
      end else begin
        in_valid = 1'b0;
      end
    end
    drain("random");
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation time limit reached");
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_tag    = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_in_ready",  64'(in_ready),  64'd1);
    check("reset_diff",      64'(out_diff),  64'd0);
    check("reset_cout",      64'(out_cout),  64'd0);
    check("reset_tag",       64'(out_tag),   64'd0);

    run_op(32'h0000_000A, 32'h0000_0003, 4'h5, 32'h0000_0007, 1'b1, 1'b0, 1'b0, "sub_10_3");
    run_op(32'h0000_0000, 32'h0000_0001, 4'h2, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, "sub_0_1");
    run_op(32'h8000_0000, 32'h0000_0001, 4'h3, 32'h7FFF_FFFF, 1'b1, 1'b0, 1'b1, "sub_min_1");
    run_op(32'h1234_5678, 32'h1234_5678, 4'h4, 32'h0000_0000, 1'b1, 1'b1, 1'b0, "sub_equal");
    drain("directed");

    stall_test();
    bubble_test();
    reset_test();
    drain("reset");
    random_test();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
